// File: rtl/store_unit.sv
// Memory-stage store path: lane alignment, byte enables and a req/ready handshake to the dcache.
// Optional STORE_MISALIGN_TRAP_EN drops misaligned SH/SW and pulses the misalign output.
module store_unit #(
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              st_valid,
    input  logic [31:0]       addr,
    input  logic [31:0]       rs2_data,
    input  logic [2:0]        funct3,
    input  logic              dcache_ready,
    output logic              dcache_req,
    output logic [31:0]       dcache_addr,
    output logic [31:0]       dcache_din,
    output logic [3:0]        dcache_we,
    output logic              store_pause,
    output logic [PERF_W-1:0] perf_store_wait
`ifdef STORE_MISALIGN_TRAP_EN
    ,
    output logic              misalign
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic        is_store;
    logic        bad_align;
    logic        store_go;
    logic [3:0]  lane_we;
    logic [31:0] lane_din;
    logic [3:0]  we_q;

    // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        is_store = 1'b1;
        lane_we  = 4'b0000;
        lane_din = rs2_data;
        case (funct3)
            3'b000: begin
                lane_we  = 4'b0001 << addr[1:0];
                lane_din = {4{rs2_data[7:0]}};
            end
            3'b001: begin
                lane_we  = 4'b0011 << {addr[1], 1'b0};
                lane_din = {2{rs2_data[15:0]}};
            end
            3'b010: begin
                lane_we  = 4'b1111;
                lane_din = rs2_data;
            end
            default: is_store = 1'b0;
        endcase
    end

`ifdef STORE_MISALIGN_TRAP_EN
    assign bad_align = ((funct3 == 3'b001) && addr[0]) ||
                       ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
`else
    assign bad_align = 1'b0;
`endif

    assign store_go = st_valid && is_store && !bad_align;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // stall only matters in DONE: it keeps a held instruction from issuing a second write
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (store_go) state_d = ISSUE;
            ISSUE:   if (dcache_ready) state_d = DONE;
            DONE:    if (!stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dcache_req  = 1'b0;
        dcache_we   = 4'b0000;
        store_pause = 1'b0;
        case (state_q)
            IDLE:    store_pause = store_go;
            ISSUE: begin
                dcache_req  = 1'b1;
                dcache_we   = we_q;
                store_pause = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: the request registers are cleared on reset so the dcache never sees stale data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dcache_addr <= 32'h0;
            dcache_din  <= 32'h0;
            we_q        <= 4'b0000;
        end else if ((state_q == IDLE) && store_go) begin
            dcache_addr <= {addr[31:2], 2'b00};
            dcache_din  <= lane_din;
            we_q        <= lane_we;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_store_wait <= '0;
        end else if ((state_q == ISSUE) && !dcache_ready && (perf_store_wait != '1)) begin
            perf_store_wait <= perf_store_wait + 1'b1;
        end
    end

`ifdef STORE_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) misalign <= 1'b0;
        else          misalign <= (state_q == IDLE) && st_valid && is_store && bad_align;
    end
`endif

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed cases plus randomized stores against a
// transaction-level model of lane placement, handshake timing and the wait counter.
module tb_store_unit;

    localparam int TB_PERF_W = 5;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 stall;
    logic                 st_valid;
    logic [31:0]          addr;
    logic [31:0]          rs2_data;
    logic [2:0]           funct3;
    logic                 dcache_ready;
    logic                 dcache_req;
    logic [31:0]          dcache_addr;
    logic [31:0]          dcache_din;
    logic [3:0]           dcache_we;
    logic                 store_pause;
    logic [TB_PERF_W-1:0] perf_store_wait;
`ifdef STORE_MISALIGN_TRAP_EN
    logic                 misalign;
`endif

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int pause_cnt = 0;
    int req_cnt = 0;
    logic [TB_PERF_W-1:0] exp_perf = '0;

    store_unit #(.PERF_W(TB_PERF_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .st_valid        (st_valid),
        .addr            (addr),
        .rs2_data        (rs2_data),
        .funct3          (funct3),
        .dcache_ready    (dcache_ready),
        .dcache_req      (dcache_req),
        .dcache_addr     (dcache_addr),
        .dcache_din      (dcache_din),
        .dcache_we       (dcache_we),
        .store_pause     (store_pause),
        .perf_store_wait (perf_store_wait)
`ifdef STORE_MISALIGN_TRAP_EN
        ,
        .misalign        (misalign)
`endif
    );

    always #5 clk = ~clk;

    // Inputs settle 1ns after posedge, so the negedge sample equals what the next edge sees.
    always @(negedge clk) begin
        if (reset_n) begin
            pause_cnt += int'(store_pause);
            req_cnt   += int'(dcache_req);
            if (dcache_req && dcache_ready) wr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: access size from funct3, lanes are the naturally aligned slot holding addr.
    task automatic model_lanes(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                               output logic legal, output logic mis,
                               output logic [3:0] we, output logic [31:0] din);
        int size;
        int off;
        legal = (f3 <= 3'd2);
        size  = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
`ifdef STORE_MISALIGN_TRAP_EN
        mis = legal && ((a % size) != 0);
`else
        mis = 1'b0;
`endif
        off = int'(a % 4) - int'(a % 4) % size;
        we  = 4'(((1 << size) - 1) << off);
        if (size == 1)      din = {24'h0, d[7:0]} * 32'h0101_0101;
        else if (size == 2) din = {16'h0, d[15:0]} * 32'h0001_0001;
        else                din = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_ignored();
        addr     = $urandom;
        rs2_data = $urandom;
        funct3   = 3'($urandom);
    endtask

    // One store instruction: IDLE capture, wait_n not-ready ISSUE cycles, stall_n held DONE cycles.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                            input int wait_n, input int stall_n);
        logic       legal, mis;
        logic [3:0] we;
        logic [31:0] din;
        int         wr0;
        model_lanes(a, d, f3, legal, mis, we, din);
        wr0 = wr_cnt;

        st_valid = 1'b1; addr = a; rs2_data = d; funct3 = f3;
        stall = 1'($urandom); dcache_ready = 1'($urandom);
        @(negedge clk);
        check("idle_pause", 32'(store_pause), 32'(legal && !mis));
        check("idle_req", 32'(dcache_req), 32'd0);
        check("idle_we", 32'(dcache_we), 32'd0);
        next_cycle();

        if (!legal || mis) begin
            st_valid = 1'b0; scramble_ignored();
            @(negedge clk);
            check("drop_req", 32'(dcache_req), 32'd0);
            check("drop_pause", 32'(store_pause), 32'd0);
`ifdef STORE_MISALIGN_TRAP_EN
            check("misalign_pulse", 32'(misalign), 32'(mis));
`endif
            next_cycle();
            @(negedge clk);
`ifdef STORE_MISALIGN_TRAP_EN
            check("misalign_end", 32'(misalign), 32'd0);
`endif
            check("drop_writes", 32'(wr_cnt), 32'(wr0));
            next_cycle();
        end else begin
            for (int i = 0; i <= wait_n; i++) begin
                dcache_ready = (i == wait_n);
                stall = 1'($urandom);
                scramble_ignored();
                @(negedge clk);
                check("issue_req", 32'(dcache_req), 32'd1);
                check("issue_pause", 32'(store_pause), 32'd1);
                check("issue_we", 32'(dcache_we), 32'(we));
                check("issue_addr", dcache_addr, {a[31:2], 2'b00});
                check("issue_din", dcache_din, din);
                check("issue_perf", 32'(perf_store_wait), 32'(exp_perf));
                next_cycle();
                if (!dcache_ready && exp_perf != '1) exp_perf = exp_perf + 1'b1;
            end
            for (int j = 0; j <= stall_n; j++) begin
                stall = (j < stall_n);
                dcache_ready = 1'($urandom);
                @(negedge clk);
                check("done_req", 32'(dcache_req), 32'd0);
                check("done_pause", 32'(store_pause), 32'd0);
                check("done_we", 32'(dcache_we), 32'd0);
                check("done_perf", 32'(perf_store_wait), 32'(exp_perf));
                next_cycle();
            end
            st_valid = 1'b0; stall = 1'($urandom); dcache_ready = 1'($urandom);
            @(negedge clk);
            check("bubble_pause", 32'(store_pause), 32'd0);
            check("bubble_req", 32'(dcache_req), 32'd0);
            check("one_write", 32'(wr_cnt), 32'(wr0 + 1));
            next_cycle();
        end
    endtask

    initial begin
        int p0, r0, w0;
        logic [2:0] f3;

        reset_n = 1'b0; stall = 1'b0; st_valid = 1'b0; addr = '0; rs2_data = '0;
        funct3 = 3'b111; dcache_ready = 1'b0;
        #2;
        check("rst_req", 32'(dcache_req), 32'd0);
        check("rst_we", 32'(dcache_we), 32'd0);
        check("rst_addr", dcache_addr, 32'd0);
        check("rst_din", dcache_din, 32'd0);
        check("rst_perf", 32'(perf_store_wait), 32'd0);
        check("rst_pause", 32'(store_pause), 32'd0);
`ifdef STORE_MISALIGN_TRAP_EN
        check("rst_misalign", 32'(misalign), 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        next_cycle();

        p0 = pause_cnt; r0 = req_cnt;
        do_store(32'h0000_1003, 32'h0000_00AB, 3'b000, 0, 0);
        check("sb_pause_cycles", 32'(pause_cnt - p0), 32'd2);
        do_store(32'h0000_2002, 32'hDEAD_1234, 3'b001, 0, 0);
        p0 = pause_cnt; r0 = req_cnt;
        do_store(32'h0000_3000, 32'hCAFE_F00D, 3'b010, 3, 0);
        check("sw_pause_cycles", 32'(pause_cnt - p0), 32'd5);
        check("sw_req_cycles", 32'(req_cnt - r0), 32'd4);
        check("sw_perf", 32'(perf_store_wait), 32'd3);
        do_store(32'h0000_3004, 32'h1122_3344, 3'b010, 0, 4);
        do_store(32'h0000_4002, 32'h5566_7788, 3'b010, 1, 0);
        do_store(32'h0000_5001, 32'h0000_BEEF, 3'b001, 0, 0);
        do_store(32'h0000_6000, 32'h0000_0000, 3'b101, 0, 0);

        // Reset while a request is outstanding
        w0 = wr_cnt;
        st_valid = 1'b1; addr = 32'h0000_7000; rs2_data = 32'h0BAD_F00D; funct3 = 3'b010;
        dcache_ready = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("pre_rst_req", 32'(dcache_req), 32'd1);
        #1;
        st_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(dcache_req), 32'd0);
        check("mid_rst_we", 32'(dcache_we), 32'd0);
        check("mid_rst_pause", 32'(store_pause), 32'd0);
        check("mid_rst_perf", 32'(perf_store_wait), 32'd0);
        check("mid_rst_addr", dcache_addr, 32'd0);
        exp_perf = '0;
        @(negedge clk);
        reset_n = 1'b1;
        next_cycle();
        @(negedge clk);
        check("mid_rst_idle_req", 32'(dcache_req), 32'd0);
        check("mid_rst_writes", 32'(wr_cnt), 32'(w0));
        next_cycle();

        for (int n = 0; n < 40; n++) begin
            f3 = ($urandom_range(0, 3) == 3) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            do_store($urandom, $urandom, f3, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        do_store(32'h0000_8000, 32'h7777_7777, 3'b010, 40, 1);
        check("perf_saturated", 32'(perf_store_wait), 32'((1 << TB_PERF_W) - 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
